// File: rtl/pc_fetch_unit.sv
// Program-counter fetch unit: BOOT/RUN/HALT sequencing and priority next-PC selection.
// Optional target alignment checking with sticky error flag is enabled by PC_ALIGN_CHECK_EN.
module pc_fetch_unit #(
  parameter int unsigned     WL          = 32,
  parameter logic [WL-1:0]   RESET_VEC   = '0,
  parameter logic [WL-1:0]   EXC_VEC     = WL'(32'h0000_0180),
  parameter int unsigned     INC         = 4,
  parameter int unsigned     BOOT_CYCLES = 2
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          EN,
  input  logic          halt,
  input  logic          resume,
  input  logic          exc_req,
  input  logic          br_taken,
  input  logic [WL-1:0] br_target,
  input  logic          jmp,
  input  logic [WL-1:0] jmp_target,
  output logic [WL-1:0] PC_out,
  output logic [WL-1:0] PC_plus,
  output logic          fetch_valid,
  output logic          redirected,
  output logic [1:0]    state_o
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic          misalign_err
`endif
);

  localparam int unsigned   CNT_W     = 4;
  localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_CYCLES - 1);
  localparam logic [WL-1:0] INC_W     = WL'(INC);

  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WL-1:0]    pc_q, pc_d;
  logic             fv_q, fv_d;
  logic             redir_q, redir_d;
  logic [WL-1:0]    tgt_c;

  // Branch is the older instruction, so it shadows a simultaneous jump.
  assign tgt_c = br_taken ? br_target : jmp_target;

`ifdef PC_ALIGN_CHECK_EN
  localparam logic [WL-1:0] ALIGN_MASK = WL'((1 << $clog2(INC)) - 1);
  logic mis_q, mis_d;
  logic tgt_bad_c;
  assign tgt_bad_c = |(tgt_c & ALIGN_MASK);
`endif

  // Next-state, next-PC and flag selection
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    redir_d = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
    mis_d   = mis_q;
`endif
    case (state_q)
      ST_BOOT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == BOOT_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (exc_req) begin
          pc_d    = EXC_VEC;
          redir_d = 1'b1;
        end else if (br_taken || jmp) begin
          redir_d = 1'b1;
`ifdef PC_ALIGN_CHECK_EN
          if (tgt_bad_c) begin
            pc_d  = EXC_VEC;
            mis_d = 1'b1;
          end else begin
            pc_d = tgt_c;
          end
`else
          pc_d = tgt_c;
`endif
        end else if (EN) begin
          pc_d = pc_q + INC_W;
        end
        if (halt) state_d = ST_HALT;
      end
      ST_HALT: begin
        // An exception wakes the core; branches and jumps are dropped here.
        if (exc_req) begin
          pc_d    = EXC_VEC;
          redir_d = 1'b1;
          state_d = ST_RUN;
        end else if (resume) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_BOOT;
    endcase
    fv_d = (state_d == ST_RUN);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_BOOT;
      cnt_q   <= '0;
      pc_q    <= RESET_VEC;
      fv_q    <= 1'b0;
      redir_q <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      fv_q    <= fv_d;
      redir_q <= redir_d;
`ifdef PC_ALIGN_CHECK_EN
      mis_q   <= mis_d;
`endif
    end
  end

  assign PC_out      = pc_q;
  assign PC_plus     = pc_q + INC_W;
  assign fetch_valid = fv_q;
  assign redirected  = redir_q;
  assign state_o     = state_q;
`ifdef PC_ALIGN_CHECK_EN
  assign misalign_err = mis_q;
`endif

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Parametrised program-counter unit for the pipelined MIPS core; replaces the fixed 32-entry PC lookup.
- Holds the architectural fetch PC and produces PC and PC+INC for the IF stage.
- Selects the next PC by priority from exception, EX-stage branch, ID-stage jump, stall and sequential sources.
- Adds a post-reset boot delay, a halt state and a fetch-valid qualifier for the IF/ID register.

Parameters:
- WL, 32, PC word length in bits.
- RESET_VEC, 0, PC value loaded on reset (WL bits).
- EXC_VEC, 32'h0000_0180, exception handler address.
- INC, 4, sequential increment.
- BOOT_CYCLES, 2, cycles spent in BOOT after reset release before the first valid fetch (1..15).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-high reset.
- EN  in  1  1 = advance; 0 = stall (hold PC).
- halt  in  1  request to stop fetching.
- resume  in  1  leave HALT.
- exc_req  in  1  exception redirect to EXC_VEC.
- br_taken  in  1  EX-stage branch taken.
- br_target  in  WL  branch target.
- jmp  in  1  ID-stage jump/jal/jr.
- jmp_target  in  WL  jump target.
- PC_out  out  WL  current fetch PC (registered).
- PC_plus  out  WL  PC_out + INC (combinational).
- fetch_valid  out  1  PC_out is a real fetch this cycle.
- redirected  out  1  pulse, 1 cycle: the last PC update was a non-sequential redirect (IF/ID flush hint).
- state_o  out  2  00 BOOT, 01 RUN, 10 HALT.

Behaviour:
- Reset (async, any time, including mid-redirect):
  - PC_out=RESET_VEC, state=BOOT, boot counter=0.
  - fetch_valid=0, redirected=0.
- BOOT:
  - Counter increments each cycle; PC_out holds.
  - When the counter reaches BOOT_CYCLES-1: next state RUN, fetch_valid=1 from the following cycle.
  - All redirect inputs are ignored in BOOT.
- RUN, next PC by priority:
  1. exc_req → EXC_VEC.
  2. br_taken → br_target.
  3. jmp → jmp_target.
  4. EN=0 → hold.
  5. Otherwise PC_out+INC.
- Redirects (exc/br/jmp) override a stall: a redirect is taken even with EN=0.
- redirected=1 in the cycle after any redirect is applied; otherwise 0.
- If br_taken and jmp are both asserted, the branch wins; the jump is lost (older instruction precedence).
- halt in RUN:
  - Next state HALT. A redirect in the same cycle is still applied to PC_out first.
  - fetch_valid=0 while in HALT; PC_out holds.
- HALT:
  - resume → RUN next cycle.
  - exc_req in HALT → PC_out=EXC_VEC and state RUN (exception wakes the core).
  - br/jmp are ignored in HALT.
  - halt and resume both asserted in RUN: halt wins. Both asserted in HALT: resume wins.
- fetch_valid = (state==RUN) registered.
- Arithmetic is modulo 2^WL: PC_out of all-ones−INC+1 wraps to the low addresses, no flag.
- Targets are used unmodified; no alignment masking unless the optional feature is enabled.

Optional Feature:
- Macro PC_ALIGN_CHECK_EN.
- When defined:
  - Any redirect target (br_target or jmp_target) with low log2(INC) bits nonzero is not applied.
  - Instead PC_out=EXC_VEC, redirected=1.
  - Extra output misalign_err (1 bit) sets sticky, and is cleared only by RST.
  - EXC_VEC itself is never checked.
- When undefined: targets are taken unchecked, and the misalign_err port does not exist.

Test Plan:
- RST pulse mid-cycle, BOOT_CYCLES=2 → PC_out=0 immediately, async. fetch_valid=0 for 2 cycles after release, then 1. PC sequence 0,4,8,12.
- RUN at PC=0x10, EN=0 for 3 cycles → PC_out stays 0x10, fetch_valid=1. EN=1 → 0x14.
- PC=0x20, EN=0, br_taken=1, br_target=0x100, jmp=1, jmp_target=0x200 in the same cycle → PC_out=0x100, redirected=1 for exactly one cycle, then 0x104.
- halt=1 with jmp=1 to 0x40 → PC_out=0x40, state=HALT, fetch_valid=0. PC holds for 5 cycles. resume=1 → RUN, next PC 0x44.
- In HALT, exc_req=1 → PC_out=0x180, state=RUN. Start from PC=0xFFFF_FFFC sequential → next PC 0x0000_0000.
- With PC_ALIGN_CHECK_EN: br_taken to 0x102 → PC_out=0x180, misalign_err=1 and stays 1 until RST.
